hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 15 +
 rtl/sat_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and default sizing of the statistics and memory-wait counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } hz_state_e;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; asynchronous clear
// via rst plus a synchronous clear that overrides the enable.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory stalls, taken branches, load-use
// hazards and jumps in the same cycle, with stall/flush statistics.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    hz_state_e   state_q;
    hz_state_e   state_d;
    logic        timeout_q;
    logic        timeout_d;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall;
    logic load_use;
    logic soft_ok;
    logic wait_hit;
    logic stall_inc;
    logic flush_inc;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_MemRead & (ex_rt != 5'd0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    // The cycle after a stall or flush the ID slot is stale, so only the
    // hard hazards (memory, branch) may act on it.
    assign soft_ok   = (state_q == RUN) || (state_q == MEM_WAIT);
    // wait_cnt holds the stall cycles already elapsed; this one is the next.
    assign wait_hit  = mem_stall && ((int'(wait_cnt) + 1) >= TIMEOUT);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = RUN;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            stall_inc  = 1'b1;
            state_d    = MEM_WAIT;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = FLUSH;
        end else if (load_use && soft_ok) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = LD_STALL;
        end else if (jump && soft_ok) begin
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            state_d    = FLUSH;
        end
    end

    assign timeout_d = timeout_q | wait_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q | (wait_hit & ~rst);
    assign state       = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .en_i  (stall_inc),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .en_i  (flush_inc),
        .cnt_o (flush_cnt)
    );

    // Cleared as soon as the stall ends, i.e. on the way out of MEM_WAIT.
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~mem_stall),
        .en_i  (mem_stall),
        .cnt_o (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters (CNT_W=4, TIMEOUT=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_MemRead, jump, branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_MemRead   (ex_MemRead),
        .ex_rt        (ex_rt),
        .jump         (jump),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_hold    (pipe_hold),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Controls packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}.
    function automatic logic [4:0] ctl();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_MemRead = 1'b0; jump = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #2;
        checks++;
        if (ctl() !== 5'b00110) begin failures++; $display("FAIL reset_ctl got=%b exp=00110", ctl()); end
        checks++;
        if ({state, stall_cnt, flush_cnt, mem_timeout} !== 11'd0) begin
            failures++; $display("FAIL reset_state got st=%0d sc=%0d fc=%0d to=%b exp all 0", state, stall_cnt, flush_cnt, mem_timeout);
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (ctl() !== 5'b11000 || state !== 2'd0) begin failures++; $display("FAIL after_reset got ctl=%b st=%0d exp ctl=11000 st=0", ctl(), state); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        checks++;
        if (ctl() !== 5'b00010) begin failures++; $display("FAIL lu_rs_ctl got=%b exp=00010", ctl()); end
        cyc();
        idle();
        #1;
        checks++;
        if (state !== 2'd1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_rs_state got st=%0d sc=%0d exp st=1 sc=1", state, stall_cnt); end
        checks++;
        if (ctl() !== 5'b11000) begin failures++; $display("FAIL lu_stall_once got=%b exp=11000", ctl()); end
        cyc();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL lu_return got st=%0d exp=0", state); end
        // rt match only counts when the ID instruction actually reads rt
        ex_MemRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b11000) begin failures++; $display("FAIL lu_rt_unused got=%b exp=11000", ctl()); end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b00010) begin failures++; $display("FAIL lu_rt_used got=%b exp=00010", ctl()); end
        cyc();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 4'd2) begin failures++; $display("FAIL lu_rt_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (ctl() !== 5'b11000) begin failures++; $display("FAIL zero_reg_ctl got=%b exp=11000", ctl()); end
        cyc();
        idle();
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 4'd0) begin failures++; $display("FAIL zero_reg_state got st=%0d sc=%0d exp 0 0", state, stall_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        branch_taken = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        checks++;
        if (ctl() !== 5'b11110) begin failures++; $display("FAIL br_over_lu got=%b exp=11110", ctl()); end
        cyc();
        idle();
        // In FLUSH a load-use or jump on the stale slot is ignored
        jump = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1;
        checks++;
        if (state !== 2'd3 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            failures++; $display("FAIL br_counts got st=%0d fc=%0d sc=%0d exp st=3 fc=1 sc=0", state, flush_cnt, stall_cnt);
        end
        checks++;
        if (ctl() !== 5'b11000) begin failures++; $display("FAIL flush_ignores_soft got=%b exp=11000", ctl()); end
        // but a taken branch is still honoured in FLUSH
        branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b11110) begin failures++; $display("FAIL flush_honours_br got=%b exp=11110", ctl()); end
        // and a memory stall beats the branch
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl() !== 5'b00001) begin failures++; $display("FAIL mem_over_br got=%b exp=00001", ctl()); end
        cyc();
        idle();
        #1;
        checks++;
        if (state !== 2'd2 || stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            failures++; $display("FAIL mem_over_br_cnt got st=%0d sc=%0d fc=%0d exp 2 1 1", state, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (ctl() !== 5'b00001) begin failures++; $display("FAIL mw_hold_%0d got=%b exp=00001", k, ctl()); end
            cyc();
            checks++;
            if (state !== 2'd2) begin failures++; $display("FAIL mw_state_%0d got=%0d exp=2", k, state); end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (ctl() !== 5'b11000) begin failures++; $display("FAIL mw_ready got=%b exp=11000", ctl()); end
        cyc();
        mem_req = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 4'd3 || mem_timeout !== 1'b0) begin
            failures++; $display("FAIL mw_done got st=%0d sc=%0d to=%b exp 0 3 0", state, stall_cnt, mem_timeout);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            checks++;
            if (mem_timeout !== (k >= 4)) begin failures++; $display("FAIL to_cycle_%0d got=%b exp=%b", k, mem_timeout, (k >= 4)); end
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        mem_req = 1'b0;
        #1;
        checks++;
        if (mem_timeout !== 1'b1 || state !== 2'd0 || stall_cnt !== 4'd6) begin
            failures++; $display("FAIL to_sticky got to=%b st=%0d sc=%0d exp 1 0 6", mem_timeout, state, stall_cnt);
        end
        // Reset in the middle of a wait abandons it
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || mem_timeout !== 1'b0 || stall_cnt !== 4'd0) begin
            failures++; $display("FAIL to_rst got st=%0d to=%b sc=%0d exp 0 0 0", state, mem_timeout, stall_cnt);
        end
        cyc();
        idle();
        rst = 1'b0;
        cyc();
        checks++;
        if (state !== 2'd0 || mem_timeout !== 1'b0) begin failures++; $display("FAIL to_resume got st=%0d to=%b exp 0 0", state, mem_timeout); end
    endtask

    task automatic test_saturation();
        int exp_fc;
        do_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        cyc();
        idle();
        cyc();
        exp_fc = 0;
        for (int i = 0; i < 20; i++) begin
            jump = 1'b1;
            #1;
            checks++;
            if (ctl() !== 5'b11100) begin failures++; $display("FAIL jmp_ctl_%0d got=%b exp=11100", i, ctl()); end
            cyc();
            jump = 1'b0;
            exp_fc = (exp_fc < 15) ? exp_fc + 1 : 15;
            checks++;
            if (flush_cnt !== 4'(exp_fc) || state !== 2'd3) begin
                failures++; $display("FAIL jmp_cnt_%0d got fc=%0d st=%0d exp fc=%0d st=3", i, flush_cnt, state, exp_fc);
            end
            cyc();
        end
        checks++;
        if (stall_cnt !== 4'd1) begin failures++; $display("FAIL sat_stall got=%0d exp=1", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            jump = 1'b1; cyc(); jump = 1'b0; cyc();
        end
        jump = 1'b1;
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (flush_cnt !== 4'd0 || stall_cnt !== 4'd0 || state !== 2'd0) begin
            failures++; $display("FAIL sat_rst got fc=%0d sc=%0d st=%0d exp 0 0 0", flush_cnt, stall_cnt, state);
        end
        jump = 1'b0;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            jump = 1'b1; cyc(); jump = 1'b0; cyc();
        end
        checks++;
        if (flush_cnt !== 4'd2) begin failures++; $display("FAIL sat_restart got=%0d exp=2", flush_cnt); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
